hilo_md_ctrl: RTL



---
 rtl/hilo_md_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/hilo_md_ctrl.sv
// HI/LO multiply/divide sequencing controller for the EX stage.
// A multiply is computed in one shot and then held for a fixed number of wait
// cycles. A divide runs a 32-step restoring divider on operand magnitudes and
// applies signs in DONE. EX is stalled while an operation is in flight. An
// exception flush abandons the operation without touching HI/LO.
module hilo_md_ctrl #(
   parameter int unsigned MUL_CYCLES  = 2,
   parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ex_valid,
   input  logic [2:0]  ex_md_op,
   input  logic [31:0] ex_src_a,
   input  logic [31:0] ex_src_b,
   input  logic        flush,
   output logic        md_stall,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_CYCLES - 1);
   localparam logic [4:0] DIV_CNT_INIT = 5'd31;

   // Magnitude of a two's-complement word; 0x80000000 maps to itself, which
   // is the correct unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (32'd0 - v) : v;
   endfunction

   // Conditional two's-complement negation used for the final sign fix.
   function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
      return neg ? (32'd0 - v) : v;
   endfunction

   state_t        state_r, state_next_s;
   logic [4:0]    cnt_r;
   logic [63:0]   prod_r;
   logic [31:0]   divisor_r;
   logic [31:0]   quo_r;        // dividend bits shift out, quotient bits shift in
   logic [31:0]   rem_r;
   logic [31:0]   a_raw_r;
   logic          quo_sign_r;
   logic          rem_sign_r;
   logic          div_zero_r;
   logic          is_div_r;

   logic          req_ok_s;
   logic          is_mul_op_s;
   logic          is_div_op_s;
   logic          is_signed_s;
   logic          start_s;
   logic          mthi_s;
   logic          mtlo_s;
   logic [63:0]   ext_a_s;
   logic [63:0]   ext_b_s;
   logic [63:0]   prod_s;
   logic [32:0]   shift_s;
   logic [32:0]   trial_s;
   logic          q_bit_s;
   logic [31:0]   done_hi_s;
   logic [31:0]   done_lo_s;
   logic          hilo_wr_s;

   // Request decode: flush dominates every request; only IDLE accepts one.
   always_comb begin
      req_ok_s    = ex_valid & ~flush & (state_r == ST_IDLE);
      is_mul_op_s = (ex_md_op == OP_MULT) | (ex_md_op == OP_MULTU);
      is_div_op_s = (ex_md_op == OP_DIV)  | (ex_md_op == OP_DIVU);
      is_signed_s = (ex_md_op == OP_MULT) | (ex_md_op == OP_DIV);
      start_s     = req_ok_s & (is_mul_op_s | is_div_op_s);
      mthi_s      = req_ok_s & (ex_md_op == OP_MTHI);
      mtlo_s      = req_ok_s & (ex_md_op == OP_MTLO);
   end

   // Full 64-bit product; sign extension makes the truncated product correct for MULT.
   always_comb begin
      if (is_signed_s) begin
         ext_a_s = {{32{ex_src_a[31]}}, ex_src_a};
         ext_b_s = {{32{ex_src_b[31]}}, ex_src_b};
      end else begin
         ext_a_s = {32'd0, ex_src_a};
         ext_b_s = {32'd0, ex_src_b};
      end
      prod_s = ext_a_s * ext_b_s;
   end

   // One restoring divide step: shift in next dividend bit, trial-subtract divisor.
   always_comb begin
      shift_s = {rem_r, quo_r[31]};
      trial_s = shift_s - {1'b0, divisor_r};
      q_bit_s = ~trial_s[32];
   end

   // Result selection for the HI/LO write performed in DONE.
   always_comb begin
      if (div_zero_r) begin
         done_hi_s = a_raw_r;
         done_lo_s = DIV_ZERO_LO;
      end else if (is_div_r) begin
         done_hi_s = neg_if(rem_r, rem_sign_r);
         done_lo_s = neg_if(quo_r, quo_sign_r);
      end else begin
         done_hi_s = prod_r[63:32];
         done_lo_s = prod_r[31:0];
      end
      hilo_wr_s = (state_r == ST_DONE) & ~flush;
   end

   // FSM next-state logic; flush abandons MUL/DIV immediately.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_next_s = is_mul_op_s ? ST_MUL : ST_DIV;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_MUL, ST_DIV: begin
            if (flush) begin
               state_next_s = ST_IDLE;
            end else if (cnt_r == 5'd0) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = state_r;
            end
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Status outputs: stall covers the start cycle and the busy states, not DONE.
   always_comb begin
      md_stall = start_s | (((state_r == ST_MUL) | (state_r == ST_DIV)) & ~flush);
      md_busy  = (state_r != ST_IDLE);
      md_done  = (state_r == ST_DONE);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Operand capture at start and per-cycle multiply wait / divide stepping.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_r      <= 5'd0;
         prod_r     <= 64'd0;
         divisor_r  <= 32'd0;
         quo_r      <= 32'd0;
         rem_r      <= 32'd0;
         a_raw_r    <= 32'd0;
         quo_sign_r <= 1'b0;
         rem_sign_r <= 1'b0;
         div_zero_r <= 1'b0;
         is_div_r   <= 1'b0;
      end else if (start_s && is_mul_op_s) begin
         prod_r     <= prod_s;
         cnt_r      <= MUL_CNT_INIT;
         is_div_r   <= 1'b0;
         div_zero_r <= 1'b0;
      end else if (start_s) begin
         divisor_r  <= is_signed_s ? abs32(ex_src_b) : ex_src_b;
         quo_r      <= is_signed_s ? abs32(ex_src_a) : ex_src_a;
         rem_r      <= 32'd0;
         a_raw_r    <= ex_src_a;
         quo_sign_r <= is_signed_s & (ex_src_a[31] ^ ex_src_b[31]);
         rem_sign_r <= is_signed_s & ex_src_a[31];
         div_zero_r <= (ex_src_b == 32'd0);
         is_div_r   <= 1'b1;
         cnt_r      <= DIV_CNT_INIT;
      end else if ((state_r == ST_DIV) && !flush) begin
         rem_r <= q_bit_s ? trial_s[31:0] : shift_s[31:0];
         quo_r <= {quo_r[30:0], q_bit_s};
         cnt_r <= cnt_r - 5'd1;
      end else if ((state_r == ST_MUL) && !flush) begin
         cnt_r <= cnt_r - 5'd1;
      end
   end

   // Architectural HI/LO: result write in DONE, or MTHI/MTLO while IDLE.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi_o <= 32'd0;
         lo_o <= 32'd0;
      end else if (hilo_wr_s) begin
         hi_o <= done_hi_s;
         lo_o <= done_lo_s;
      end else begin
         if (mthi_s) begin
            hi_o <= ex_src_a;
         end
         if (mtlo_s) begin
            lo_o <= ex_src_a;
         end
      end
   end

endmodule
